// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Instruction-fetch front end feeding the IF/ID register.
//               Owns the fetch PC and issues in-order requests to a pipelined,
//               variable-latency instruction memory. Returned words are
//               buffered in a small prefetch queue and presented to decode
//               over a valid/ready handshake. A redirect from EX flushes the
//               queue and drops wrong-path responses still in flight.
// Ports       : CLK, reset            - clock, synchronous active-high reset
//               startpc               - fetch address loaded on reset
//               imem_req/addr/gnt     - request channel to instruction memory
//               imem_rvalid/rdata     - in-order response channel
//               redirect/redirect_pc  - taken-branch redirect from EX
//               id_ready              - decode accepts the queue head
//               if_valid/instr/pc     - queue head towards decode
//               fetch_pc              - next address to be requested
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit #(
  parameter int QDEPTH = 4,
  parameter int MAXOUT = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] startpc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic [63:0] fetch_pc
);

  localparam int c_PW = $clog2(QDEPTH);      // queue pointer width
  localparam int c_CW = c_PW + 1;            // queue occupancy width
  localparam int c_OW = $clog2(MAXOUT + 1);  // outstanding / drop width
  localparam int c_SW = c_CW + 1;            // occupancy + outstanding width

  localparam logic [c_OW-1:0] c_MAXOUT = c_OW'(MAXOUT);
  localparam logic [c_SW-1:0] c_QDEPTH = c_SW'(QDEPTH);

  logic [31:0]      r_instr [QDEPTH];
  logic [63:0]      r_pc    [QDEPTH];
  logic [c_PW-1:0]  r_rd;
  logic [c_PW-1:0]  r_wr;
  logic [c_CW-1:0]  r_count;
  logic [c_OW-1:0]  r_out;
  logic [c_OW-1:0]  r_drop;
  logic [63:0]      r_fetch_pc;
  logic [63:0]      r_resp_pc;

  logic             w_accept;
  logic             w_resp;
  logic             w_push;
  logic             w_pop;
  logic [c_SW-1:0]  w_credit_used;

  // Queue slots already spoken for: words buffered plus words still in flight.
  // Never issuing beyond QDEPTH of these is what keeps the queue from
  // overflowing without any back-pressure on the response channel.
  assign w_credit_used = c_SW'(r_out) + c_SW'(r_count);

  assign imem_req  = ~reset & ~redirect & (r_out < c_MAXOUT) & (w_credit_used < c_QDEPTH);
  assign imem_addr = r_fetch_pc;
  assign fetch_pc  = r_fetch_pc;

  // A response with nothing outstanding (e.g. one that straddled a reset)
  // is not ours and is ignored.
  assign w_accept = imem_req & imem_gnt;
  assign w_resp   = imem_rvalid & (r_out != '0);
  assign w_push   = w_resp & (r_drop == '0);
  assign w_pop    = if_valid & id_ready;

  assign if_valid = (r_count != '0) & ~redirect;
  assign if_instr = r_instr[r_rd];
  assign if_pc    = r_pc[r_rd];

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_fetch_pc <= startpc & ~64'h3;
      r_resp_pc  <= startpc & ~64'h3;
      for (int i = 0; i < QDEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (redirect) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_fetch_pc <= redirect_pc & ~64'h3;
      r_resp_pc  <= redirect_pc & ~64'h3;
      r_out      <= r_out - c_OW'(w_resp);
      // Every request still in flight after this cycle is wrong-path.
      // Entries already marked for dropping are part of r_out, so the new
      // drop count is simply what remains outstanding.
      r_drop     <= r_out - c_OW'(w_resp);
    end else begin
      r_out <= r_out + c_OW'(w_accept) - c_OW'(w_resp);
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 64'd4;
      end
      if (w_resp && (r_drop != '0)) begin
        r_drop <= r_drop - c_OW'(1);
      end
      if (w_push) begin
        r_instr[r_wr] <= imem_rdata;
        r_pc[r_wr]    <= r_resp_pc;
        r_wr          <= r_wr + c_PW'(1);
        r_resp_pc     <= r_resp_pc + 64'd4;
      end
      if (w_pop) begin
        r_rd <= r_rd + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Self-checking bench for fetch_prefetch_unit. An in-order
//               variable-latency memory drives the response channel; a
//               reference model tracks in-flight requests (tagged wrong-path
//               on redirect) and the expected decode stream as queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

  localparam int QDEPTH = 4;
  localparam int MAXOUT = 2;

  logic        CLK;
  logic        reset;
  logic [63:0] startpc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [63:0] fetch_pc;

  fetch_prefetch_unit #(.QDEPTH(QDEPTH), .MAXOUT(MAXOUT)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .startpc     (startpc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .fetch_pc    (fetch_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {logic [63:0] addr; int due;} pend_t;
  typedef struct {logic [63:0] addr; bit stale;} infl_t;
  typedef struct {logic [31:0] instr; logic [63:0] pc;} ent_t;

  pend_t       mem_q[$];   // memory side: granted requests awaiting response
  infl_t       m_infl[$];  // model: requests the unit is waiting on
  ent_t        m_q[$];     // model: words decode should see, in order
  logic [63:0] m_fetch_pc;
  int          lat;
  int          cyc;
  bit          late_poke;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  function automatic int n_stale();
    int n = 0;
    foreach (m_infl[i]) if (m_infl[i].stale) n++;
    return n;
  endfunction

  // One clock cycle: caller has set reset/redirect/id_ready/imem_gnt.
  task automatic step();
    bit          rv, rv_q, ereq, ev, pop, req_s, had_pend;
    logic [63:0] addr_s;
    logic [31:0] rd_s;
    infl_t       e;
    int          c;
    rv = 0; rv_q = 0; imem_rdata = '0;
    if (!reset) begin
      if (late_poke) begin
        rv = 1; imem_rdata = 32'hDEAD_BEEF; late_poke = 0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        rv = 1; rv_q = 1; imem_rdata = word_of(mem_q[0].addr);
      end
    end
    imem_rvalid = rv;
    rd_s = imem_rdata;
    #1;
    ereq = !reset && !redirect && (m_infl.size() < MAXOUT) &&
           (m_infl.size() + m_q.size() < QDEPTH);
    ev   = !reset && !redirect && (m_q.size() > 0);
    check("imem_req", 64'(imem_req), 64'(ereq));
    if (!reset) begin
      check("fetch_pc", fetch_pc, m_fetch_pc);
      if (ereq) check("imem_addr", imem_addr, m_fetch_pc);
      check("if_valid", 64'(if_valid), 64'(ev));
      if (ev) begin
        check("if_instr", 64'(if_instr), 64'(m_q[0].instr));
        check("if_pc", if_pc, m_q[0].pc);
      end
      check("count", 64'(dut.r_count), 64'(m_q.size()));
      check("outstanding", 64'(dut.r_out), 64'(m_infl.size()));
      check("drop", 64'(dut.r_drop), 64'(n_stale()));
    end
    pop = ev && id_ready;
    req_s = imem_req;
    addr_s = imem_addr;
    c = cyc;
    @(posedge CLK);
    cyc++;
    had_pend = mem_q.size() > 0;
    if (reset) mem_q.delete();
    else begin
      if (rv_q) void'(mem_q.pop_front());
      if (req_s && imem_gnt) mem_q.push_back('{addr_s, c + lat});
    end
    if (reset) begin
      late_poke = had_pend;
      m_q.delete();
      m_infl.delete();
      m_fetch_pc = startpc & ~64'h3;
    end else if (redirect) begin
      if (rv && m_infl.size() > 0) void'(m_infl.pop_front());
      foreach (m_infl[i]) m_infl[i].stale = 1;
      m_q.delete();
      m_fetch_pc = redirect_pc & ~64'h3;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rv && m_infl.size() > 0) begin
        e = m_infl.pop_front();
        if (!e.stale) m_q.push_back('{rd_s, e.addr});
      end
      if (ereq && imem_gnt) begin
        m_infl.push_back('{m_fetch_pc, 1'b0});
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset(input logic [63:0] pc);
    startpc = pc; reset = 1; redirect = 0;
    step();
    reset = 0;
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_instr", 64'(if_instr), 64'd0);
    check("rst_if_pc", if_pc, 64'd0);
    check("rst_fetch_pc", fetch_pc, pc & ~64'h3);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit hit;
    n_checks = 0; n_pass = 0; cyc = 0; late_poke = 0; lat = 1;
    reset = 1; redirect = 0; redirect_pc = '0; id_ready = 1; imem_gnt = 1;
    imem_rvalid = 0; imem_rdata = '0; startpc = '0; m_fetch_pc = '0;

    // Streaming fetch from 0x1000, 1-cycle memory, then a 10-cycle stall
    lat = 1; id_ready = 1; imem_gnt = 1;
    do_reset(64'h1000);
    check("first_req", imem_addr, 64'h1000);
    run(12);
    do_reset(64'h1000);
    id_ready = 0;
    run(10);
    check("stall_buffered", 64'(dut.r_count), 64'd4);
    check("stall_no_req", 64'(imem_req), 64'd0);
    id_ready = 1;
    run(8);

    // Two wrong-path requests in flight at latency 3, redirect to 0x3002
    lat = 3;
    do_reset(64'h2000);
    run(2);
    redirect = 1; redirect_pc = 64'h3002;
    step();
    redirect = 0;
    check("redir_drop", 64'(dut.r_drop), 64'd2);
    check("redir_next_req", imem_addr, 64'h3000);
    run(12);

    // Redirect in the same cycle as the response for the last outstanding request
    lat = 2;
    do_reset(64'h4000);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      imem_gnt = ($urandom_range(0, 1) != 0);
      id_ready = ($urandom_range(0, 2) != 0);
      if (!late_poke && m_infl.size() == 1 && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        redirect = 1; redirect_pc = 64'h5006; hit = 1;
      end
      step();
      redirect = 0;
    end
    check("redir_last_hit", 64'(hit), 64'd1);
    imem_gnt = 1; id_ready = 1;
    run(8);

    // PC wrap at the top of the address space
    lat = 1;
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    run(6);

    // Reset while 3 words are buffered and 1 request is outstanding
    lat = 2; id_ready = 0; imem_gnt = 1;
    do_reset(64'h6000);
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (m_q.size() == 3 && m_infl.size() == 1) hit = 1;
      else step();
    end
    check("midrst_setup", 64'(hit), 64'd1);
    do_reset(64'h6000);
    id_ready = 1;
    run(10);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) lat = $urandom_range(1, 4);
      id_ready    = ($urandom_range(0, 3) != 0);
      imem_gnt    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) do_reset({$urandom, $urandom});
      else step();
      redirect = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
